// File: rtl/ann_pkg.sv
// Shared types and sizing for the ANN data loader.
package ann_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned IMG_WORDS = 64;
  localparam int unsigned OUT_NODES = 16;

  localparam int unsigned IMG_AW  = $clog2(IMG_WORDS);
  localparam int unsigned NODE_AW = $clog2(OUT_NODES);
  localparam int unsigned CNT_W   = $clog2(IMG_WORDS * OUT_NODES);
  localparam int unsigned SETS_W  = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  count_t;
  typedef logic [SETS_W-1:0] sets_t;

  typedef word_t image_t   [IMG_WORDS];
  typedef word_t weights_t [IMG_WORDS][OUT_NODES];

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_IMG = 3'd1,
    LOAD_WGT = 3'd2,
    SIGNAL   = 3'd3,
    WAIT_REQ = 3'd4
  } loader_state_t;

  // Terminal counts for the two load phases.
  localparam count_t IMG_LAST = count_t'(IMG_WORDS - 1);
  localparam count_t WGT_LAST = count_t'(IMG_WORDS * OUT_NODES - 1);

  // Increment that sticks at all-ones.
  function automatic sets_t sat_inc(input sets_t v);
    return (&v) ? v : v + sets_t'(1);
  endfunction

endpackage

// File: rtl/ann_load_counter.sv
// Word counter shared by the image and weight load phases.
module ann_load_counter
  import ann_pkg::*;
(
  input  logic   clk,
  input  logic   n_rst,
  input  logic   clear,
  input  logic   enable,
  input  count_t last,
  output count_t count,
  output logic   at_last_c
);

  // Count accepted words; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + count_t'(1);
    end
  end

  assign at_last_c = (count == last);

endmodule

// File: rtl/ann_data_loader.sv
// Streams an image and successive weight sets into buffers for the ANN.
module ann_data_loader
  import ann_pkg::*;
(
  input  logic     clk,
  input  logic     n_rst,
  input  logic     frame_start,
  input  word_t    data_in,
  input  logic     data_valid,
  output logic     data_ready,
  input  logic     request_coef,
  input  logic     coef_select,
  input  logic     done_processing,
  output image_t   image,
  output weights_t weights,
  output logic     image_weights_loaded,
  output logic     bank_sel,
  output sets_t    sets_loaded,
  output logic     overrun
);

  loader_state_t state_q, state_d;

  count_t cnt;
  logic   cnt_at_last_c;
  logic   xfer_c;
  logic   start_c;
  logic   reload_c;
  logic   cnt_clear_c;
  logic   overrun_hit_c;
  logic   img_we_c;
  logic   wgt_we_c;
  count_t cnt_last_c;

  logic [IMG_AW-1:0]        img_idx;
  logic [CNT_W-NODE_AW-1:0] wgt_row;
  logic [NODE_AW-1:0]       wgt_col;

  assign xfer_c  = data_valid & data_ready;
  assign img_idx = cnt[IMG_AW-1:0];
  assign wgt_row = cnt[CNT_W-1:NODE_AW];
  assign wgt_col = cnt[NODE_AW-1:0];

  ann_load_counter u_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (cnt_clear_c),
    .enable    (xfer_c),
    .last      (cnt_last_c),
    .count     (cnt),
    .at_last_c (cnt_at_last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and phase control decode.
  always_comb begin
    state_d       = state_q;
    start_c       = 1'b0;
    reload_c      = 1'b0;
    cnt_clear_c   = 1'b0;
    overrun_hit_c = 1'b0;
    img_we_c      = 1'b0;
    wgt_we_c      = 1'b0;
    cnt_last_c    = WGT_LAST;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          start_c     = 1'b1;
          cnt_clear_c = 1'b1;
          state_d     = LOAD_IMG;
        end
      end
      LOAD_IMG: begin
        cnt_last_c    = IMG_LAST;
        img_we_c      = xfer_c;
        overrun_hit_c = request_coef;
        if (xfer_c && cnt_at_last_c) begin
          cnt_clear_c = 1'b1;
          state_d     = LOAD_WGT;
        end
      end
      LOAD_WGT: begin
        wgt_we_c      = xfer_c;
        overrun_hit_c = request_coef;
        if (xfer_c && cnt_at_last_c) begin
          cnt_clear_c = 1'b1;
          state_d     = SIGNAL;
        end
      end
      SIGNAL: begin
        overrun_hit_c = request_coef;
        state_d       = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (done_processing) begin
          state_d = IDLE;
        end else if (request_coef) begin
          reload_c    = 1'b1;
          cnt_clear_c = 1'b1;
          state_d     = LOAD_WGT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake, pulse and status registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data_ready           <= 1'b0;
      image_weights_loaded <= 1'b0;
      bank_sel             <= 1'b0;
      sets_loaded          <= '0;
      overrun              <= 1'b0;
    end else begin
      data_ready           <= (state_d == LOAD_IMG) || (state_d == LOAD_WGT);
      image_weights_loaded <= (state_d == SIGNAL);
      if (start_c) begin
        sets_loaded <= '0;
        overrun     <= 1'b0;
      end else begin
        if (state_d == SIGNAL) sets_loaded <= sat_inc(sets_loaded);
        if (overrun_hit_c)     overrun     <= 1'b1;
      end
      if (reload_c) bank_sel <= coef_select;
    end
  end

  // Image and weight buffer writes.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(IMG_WORDS); i++) begin
        image[i] <= '0;
        for (int j = 0; j < int'(OUT_NODES); j++) begin
          weights[i][j] <= '0;
        end
      end
    end else begin
      if (img_we_c) image[img_idx] <= data_in;
      if (wgt_we_c) weights[wgt_row][wgt_col] <= data_in;
    end
  end

endmodule

// File: tb/tb_ann_data_loader.sv
// Scoreboard bench for ann_data_loader: stimulus pushes expected pulses, monitor checks them.
module tb_ann_data_loader;
  import ann_pkg::*;

  logic     clk;
  logic     n_rst;
  logic     frame_start;
  word_t    data_in;
  logic     data_valid;
  logic     data_ready;
  logic     request_coef;
  logic     coef_select;
  logic     done_processing;
  image_t   image;
  weights_t weights;
  logic     image_weights_loaded;
  logic     bank_sel;
  sets_t    sets_loaded;
  logic     overrun;

  ann_data_loader dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .frame_start          (frame_start),
    .data_in              (data_in),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .request_coef         (request_coef),
    .coef_select          (coef_select),
    .done_processing      (done_processing),
    .image                (image),
    .weights              (weights),
    .image_weights_loaded (image_weights_loaded),
    .bank_sel             (bank_sel),
    .sets_loaded          (sets_loaded),
    .overrun              (overrun)
  );

  typedef struct {
    int    xfers;
    sets_t sets;
    logic  bank;
    logic  ovr;
    word_t img0;
    word_t img63;
    word_t w00;
    word_t w10;
    word_t wlast;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts transfers, pops and compares on every load pulse.
  int   mon_cyc  = 0;
  int   mon_last = -100;
  int   mon_xf   = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (image_weights_loaded) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_xfers",  mon_xf, mon_e.xfers);
          check("pulse_timing", mon_cyc - mon_last, 1);
          check("sets_loaded",  32'(sets_loaded), 32'(mon_e.sets));
          check("bank_sel",     32'(bank_sel), 32'(mon_e.bank));
          check("overrun",      32'(overrun), 32'(mon_e.ovr));
          check("image0",       32'(image[0]), 32'(mon_e.img0));
          check("image63",      32'(image[63]), 32'(mon_e.img63));
          check("w0_0",         32'(weights[0][0]), 32'(mon_e.w00));
          check("w1_0",         32'(weights[1][0]), 32'(mon_e.w10));
          check("w63_15",       32'(weights[63][15]), 32'(mon_e.wlast));
        end
        mon_xf = 0;
      end
      if (!n_rst) begin
        mon_xf = 0;
      end else if (data_valid && data_ready) begin
        mon_xf++;
        mon_last = mon_cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Stream n words base+k; optional idle gap before even words and a stray request.
  task automatic stream(input int n, input int base, input bit gaps,
                        input int req_at, input int probe_at);
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 0)) begin
        data_valid = 1'b0;
        @(posedge clk); #1;
        if (k == probe_at) check("gap_ready", 32'(data_ready), 32'd1);
      end
      data_valid   = 1'b1;
      data_in      = word_t'(base + k);
      request_coef = (k == req_at);
      @(posedge clk); #1;
      request_coef = 1'b0;
    end
    data_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic request(input logic sel);
    request_coef = 1'b1;
    coef_select  = sel;
    @(posedge clk); #1;
    request_coef = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, sb.size(), 0);
  endtask

  function automatic exp_t mk(input int xf, input int sets, input logic bank, input logic ovr,
                              input int ibase, input int wbase);
    exp_t e;
    e.xfers = xf;
    e.sets  = sets_t'(sets);
    e.bank  = bank;
    e.ovr   = ovr;
    e.img0  = word_t'(ibase);
    e.img63 = word_t'(ibase + 63);
    e.w00   = word_t'(wbase);
    e.w10   = word_t'(wbase + 16);
    e.wlast = word_t'(wbase + 1023);
    return e;
  endfunction

  initial begin
    n_rst = 1'b0; frame_start = 1'b0; data_in = '0; data_valid = 1'b0;
    request_coef = 1'b0; coef_select = 1'b0; done_processing = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(data_ready), 32'd0);
    check("rst_pulse",   32'(image_weights_loaded), 32'd0);
    check("rst_bank",    32'(bank_sel), 32'd0);
    check("rst_sets",    32'(sets_loaded), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_image5",  32'(image[5]), 32'd0);
    check("rst_w3_7",    32'(weights[3][7]), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Full frame: image 1..64, weights 0..1023.
    sb.push_back(mk(1088, 1, 1'b0, 1'b0, 1, 0));
    pulse_start();
    check("load_ready", 32'(data_ready), 32'd1);
    stream(64, 1, 1'b0, -1, -1);
    stream(1024, 0, 1'b0, -1, -1);
    wait_drain("frame1_drain");

    // Four reloads with alternating bank select.
    for (int r = 0; r < 4; r++) begin
      sb.push_back(mk(1024, 2 + r, (r % 2 == 0), 1'b0, 1, 2000 + 1000 * r));
      request((r % 2 == 0));
      stream(1024, 2000 + 1000 * r, 1'b0, -1, -1);
      wait_drain("reload_drain");
    end

    // Reload with data_valid dropped every other cycle.
    sb.push_back(mk(1024, 6, 1'b0, 1'b0, 1, 7000));
    request(1'b0);
    stream(1024, 7000, 1'b1, -1, 100);
    wait_drain("gap_drain");

    // Simultaneous request and done: done wins, bank unchanged, no pulse.
    request_coef = 1'b1; done_processing = 1'b1; coef_select = 1'b1;
    @(posedge clk); #1;
    request_coef = 1'b0; done_processing = 1'b0;
    check("done_ready", 32'(data_ready), 32'd0);
    check("done_bank",  32'(bank_sel), 32'd0);
    request(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("idle_req_ready", 32'(data_ready), 32'd0);
    check("idle_req_bank",  32'(bank_sel), 32'd0);

    // New frame with a stray request at weight transfer 500.
    sb.push_back(mk(1088, 1, 1'b0, 1'b1, 500, 10000));
    pulse_start();
    check("frame2_sets_clr", 32'(sets_loaded), 32'd0);
    stream(64, 500, 1'b0, -1, -1);
    stream(1024, 10000, 1'b0, 500, -1);
    wait_drain("overrun_drain");
    done_processing = 1'b1;
    @(posedge clk); #1;
    done_processing = 1'b0;
    check("idle_ready",      32'(data_ready), 32'd0);
    check("overrun_sticky",  32'(overrun), 32'd1);
    pulse_start();
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("sets_cleared",    32'(sets_loaded), 32'd0);

    // Reset mid weight load at transfer 300.
    stream(64, 1, 1'b0, -1, -1);
    stream(300, 0, 1'b0, -1, -1);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    check("mrst_ready",   32'(data_ready), 32'd0);
    check("mrst_image0",  32'(image[0]), 32'd0);
    check("mrst_image63", 32'(image[63]), 32'd0);
    check("mrst_w0_0",    32'(weights[0][0]), 32'd0);
    check("mrst_w18_11",  32'(weights[18][11]), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    data_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    data_valid = 1'b0;
    check("mrst_hold_ready", 32'(data_ready), 32'd0);
    check("mrst_hold_w0_0",  32'(weights[0][0]), 32'd0);
    pulse_start();
    check("restart_ready", 32'(data_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("final_queue", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ann_data_loader.md
Name: ann_data_loader

Overview:
- Upstream feeder for the ANN classifier.
- Accepts a 16-bit word stream with a valid/ready handshake from the off-chip memory interface.
- Fills a 64-word image buffer and a 64x16 weight buffer, then pulses image_weights_loaded to the ANN.
- On each ANN request_coef, reloads only the weight buffer (next coefficient set) and pulses again, until the ANN reports done_processing.

Parameters:
DATA_W, 16, word width of image pixels and weights
IMG_WORDS, 64, image words per frame (ANN input count)
OUT_NODES, 16, weights per input node (ANN output count)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse: begin loading a new image plus first weight set
data_in  in  DATA_W  stream word
data_valid  in  1  data_in valid
data_ready  out  1  loader accepts data_in this cycle
request_coef  in  1  from ANN: next weight set needed
coef_select  in  1  from ANN: which coefficient bank to fetch next
done_processing  in  1  from ANN: classification finished
image  out  DATA_W x IMG_WORDS  image buffer, image[k]
weights  out  DATA_W x IMG_WORDS x OUT_NODES  weight buffer, weights[i][j]
image_weights_loaded  out  1  one-cycle pulse: buffers valid
bank_sel  out  1  latched coef_select, drives upstream memory address MSB
sets_loaded  out  4  weight sets delivered this frame, saturates at 15
overrun  out  1  sticky: request_coef arrived while loading

Behaviour:
- The clock is clk. Reset is synchronous and active-low on n_rst. All state updates occur on the rising edge of clk.
- Reset (n_rst=0 at a rising edge):
  - state=IDLE, counter=0.
  - All image and weight entries=0.
  - image_weights_loaded=0, bank_sel=0, sets_loaded=0, overrun=0.
  - Reset mid-load abandons the load with no pulse.
- A transfer occurs when data_valid & data_ready are both high at a rising edge.
- data_ready is Moore: 1 only in LOAD_IMG and LOAD_WGT, with no dependence on data_valid.
- IDLE:
  - frame_start -> LOAD_IMG, counter=0, sets_loaded=0, overrun=0.
  - request_coef and done_processing are ignored.
- LOAD_IMG:
  - Each transfer writes image[counter] and increments counter.
  - The transfer with counter==IMG_WORDS-1 -> LOAD_WGT, counter=0.
- LOAD_WGT:
  - Transfer k writes weights[k / OUT_NODES][k % OUT_NODES], i.e. weights[k>>4][k&15] at default parameters.
  - The transfer with counter==IMG_WORDS*OUT_NODES-1 (1023) -> SIGNAL.
  - 10-bit counter; no wrap beyond 1023.
  - Gaps in data_valid stall the load indefinitely.
- SIGNAL:
  - image_weights_loaded=1 for exactly this cycle. This is the cycle after the last transfer.
  - sets_loaded+1, saturating at 15.
  - Next state WAIT_REQ.
- WAIT_REQ:
  - done_processing=1 -> IDLE. done_processing wins over a simultaneous request_coef.
  - Otherwise request_coef=1 -> LOAD_WGT, counter=0, bank_sel<=coef_select.
  - Image contents are retained.
- request_coef while in LOAD_IMG, LOAD_WGT or SIGNAL:
  - Ignored and sets overrun=1.
  - overrun clears only on reset or an accepted frame_start.
- frame_start outside IDLE is ignored.
- Buffers:
  - Outputs are registered and hold their values until overwritten.
  - During a reload, the ANN sees a mix of old and new weights. The ANN reads only after the pulse.
- Latency:
  - Full frame: 64+1024 transfers, then 1 cycle to the pulse. Minimum is 1089 cycles after the first transfer.
  - Reload: 1024 transfers + 1 cycle.

Decomposition:
- Package ann_pkg holds:
  - DATA_W, IMG_WORDS, OUT_NODES.
  - Typedef word_t (logic [DATA_W-1:0]).
  - Array typedefs image_t and weights_t.
  - Enum loader_state_t {IDLE, LOAD_IMG, LOAD_WGT, SIGNAL, WAIT_REQ}.
- One sub-module, ann_load_counter:
  - 10-bit counter with clear, enable and terminal-count compare.
  - Reused for the image and weight phases.
- Buffer write decode stays in the top.

Test Plan:
1. Reset, frame_start, stream image words 1..64 then weights 0..1023 with valid held high -> image[0]=1, image[63]=64, weights[0][0]=0, weights[1][0]=16, weights[63][15]=1023. Single image_weights_loaded pulse 1 cycle after the 1088th transfer; sets_loaded=1.
2. After test 1, assert request_coef with coef_select=1, stream weights 2000..3023 -> bank_sel=1, image unchanged, weights[0][0]=2000. Pulse once; sets_loaded=2. Repeat 4 reloads -> sets_loaded=5.
3. Drop data_valid every other cycle during the weight load -> data_ready stays 1, no extra writes, pulse only after 1024 transfers.
4. In WAIT_REQ, assert request_coef and done_processing together -> next state IDLE, data_ready=0, no pulse, bank_sel unchanged.
5. Assert request_coef mid LOAD_WGT at transfer 500 -> load continues, overrun=1, one pulse only. Next frame_start clears overrun.
6. Drive n_rst=0 for one cycle at weight transfer 300 -> state IDLE, all buffers 0, no pulse, data_ready=0 until the next frame_start.
